// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: default widths and FSM state encodings.
package shift_add_mult_pkg;

  localparam int unsigned MULT_N     = 8;
  localparam int unsigned MULT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mult_bit_counter.sv
// Loadable down-counter; tc flags the final iteration (count == 1).
module shift_add_mult_bit_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count - CNT_W'(1);
  end

  assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per cycle.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int unsigned N     = MULT_N,
  parameter int unsigned CNT_W = MULT_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] producto
);

  state_t           state;
  logic [N-1:0]     mcand;
  logic [N-1:0]     mpr;
  logic [N-1:0]     acc_hi;
  logic [N:0]       sum;
  logic [N-1:0]     mag_a;
  logic [N-1:0]     mag_b;
  logic [CNT_W-1:0] count;
  logic             tc;
  logic             cnt_load;
  logic             cnt_en;

`ifdef MULT_SIGNED_EN
  logic neg;

  // -2**(N-1) maps onto itself, which is its correct unsigned magnitude
  assign mag_a = multiplicando[N-1] ? N'(-multiplicando) : multiplicando;
  assign mag_b = multiplicador[N-1] ? N'(-multiplicador) : multiplicador;
`else
  assign mag_a = multiplicando;
  assign mag_b = multiplicador;
`endif

  assign cnt_load = (state == ST_IDLE) && start;
  assign cnt_en   = (state == ST_RUN) && (count != '0);

  shift_add_mult_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (CNT_W'(N)),
    .count    (count),
    .tc       (tc)
  );

  // Partial-product add keeps the carry so it can shift into the accumulator MSB
  always_comb begin
    sum = {1'b0, acc_hi} + (mpr[0] ? {1'b0, mcand} : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      producto <= '0;
      mcand    <= '0;
      mpr      <= '0;
      acc_hi   <= '0;
`ifdef MULT_SIGNED_EN
      neg      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= mag_a;
            mpr    <= mag_b;
            acc_hi <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
`ifdef MULT_SIGNED_EN
            neg    <= multiplicando[N-1] ^ multiplicador[N-1];
`endif
          end
        end
        ST_RUN: begin
          {acc_hi, mpr} <= {sum, mpr[N-1:1]};
          if (tc) state <= ST_DONE;
        end
        ST_DONE: begin
`ifdef MULT_SIGNED_EN
          producto <= neg ? (2*N)'(-{acc_hi, mpr}) : {acc_hi, mpr};
`else
          producto <= {acc_hi, mpr};
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult (N=8); honours MULT_SIGNED_EN for expectations.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  multiplicando;
  logic [7:0]  multiplicador;
  logic        busy;
  logic        done;
  logic [15:0] producto;

  int checks = 0;
  int errors = 0;
  int n_cyc;
  int n_busy;
  int n_done;

  shift_add_mult dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .busy          (busy),
    .done          (done),
    .producto      (producto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present operands with start for one rising edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    start         = 1'b1;
    multiplicando = a;
    multiplicador = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; counts cycles elapsed and busy-high samples before done.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    multiplicando = '0;
    multiplicador = '0;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_prod", 32'(producto), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 13 * 11
    start_op(8'd13, 8'd11);
    wait_done(n_cyc, n_busy);
    chk("t1_latency", 32'(n_cyc), 32'd9);
    chk("t1_prod", 32'(producto), 32'h008F);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_hold", 32'(producto), 32'h008F);

    // 255 * 255, busy length
    start_op(8'd255, 8'd255);
    wait_done(n_cyc, n_busy);
    chk("t2_latency", 32'(n_cyc), 32'd9);
    chk("t2_busy_len", 32'(n_busy), 32'd9);
    chk("t2_busy_at_done", 32'(busy), 32'd0);
`ifdef MULT_SIGNED_EN
    chk("t2_prod", 32'(producto), 32'h0001);
`else
    chk("t2_prod", 32'(producto), 32'hFE01);
`endif

    // Zero operands, back-to-back starts in the done cycle
    start_op(8'd0, 8'd200);
    wait_done(n_cyc, n_busy);
    chk("t3a_latency", 32'(n_cyc), 32'd9);
    chk("t3a_prod", 32'(producto), 32'd0);
    start_op(8'd200, 8'd0);
    wait_done(n_cyc, n_busy);
    chk("t3b_latency", 32'(n_cyc), 32'd9);
    chk("t3b_prod", 32'(producto), 32'd0);

    // start and operand change while busy are ignored
    @(negedge clk);
    start_op(8'd7, 8'd6);
    repeat (2) @(negedge clk);
    start_op(8'd1, 8'd1);
    wait_done(n_cyc, n_busy);
    chk("t4_latency", 32'(n_cyc), 32'd6);
    chk("t4_prod", 32'(producto), 32'd42);
    count_done(12, n_done);
    chk("t4_extra_done", 32'(n_done), 32'd0);
    chk("t4_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-run
    start_op(8'd9, 8'd9);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_prod", 32'(producto), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done(12, n_done);
    chk("t5_no_done", 32'(n_done), 32'd0);
    chk("t5_prod_after", 32'(producto), 32'd0);

    // Sign-sensitive vectors
    start_op(8'hFD, 8'd5);
    wait_done(n_cyc, n_busy);
    chk("t6a_latency", 32'(n_cyc), 32'd9);
`ifdef MULT_SIGNED_EN
    chk("t6a_prod", 32'(producto), 32'hFFF1);
`else
    chk("t6a_prod", 32'(producto), 32'h04F1);
`endif
    start_op(8'h80, 8'h80);
    wait_done(n_cyc, n_busy);
    chk("t6b_prod", 32'(producto), 32'h4000);
    start_op(8'h80, 8'd2);
    wait_done(n_cyc, n_busy);
`ifdef MULT_SIGNED_EN
    chk("t6c_prod", 32'(producto), 32'hFF00);
`else
    chk("t6c_prod", 32'(producto), 32'h0100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
